// File: rtl/mult_hilo_unit.sv
// mult_hilo_unit: multi-cycle 32x32 shift-add multiplier with the HI/LO
// register pair. It multiplies operand magnitudes over WIDTH cycles and fixes
// the sign in one final cycle, so HI/LO are only ever written as a pair.
module mult_hilo_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_mult,
  input  logic             mult_sign,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_sel,
  input  logic             hilo_read,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             done,
  output logic             hilo_stall
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0]   ONE_W      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W     = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      ONE_C      = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]      LAST_COUNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10
  } state_t;

  // Two's-complement magnitude; -2^(W-1) maps to 2^(W-1), which still fits
  // in W unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      magnitude = (~v) + ONE_W;
    end else begin
      magnitude = v;
    end
  endfunction

  state_t             state_r;
  logic [CW-1:0]      count_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic               neg_r;

  logic [2*WIDTH-1:0] acc_next_s;
  logic [2*WIDTH-1:0] result_s;

  // Partial-product step and final sign correction of the accumulator.
  always_comb begin
    acc_next_s = acc_r;
    result_s   = acc_r;
    if (mplier_r[0]) begin
      acc_next_s = acc_r + mcand_r;
    end else begin
      acc_next_s = acc_r;
    end
    if (neg_r) begin
      result_s = (~acc_r) + ONE_2W;
    end else begin
      result_s = acc_r;
    end
  end

  // Read mux and pipeline stall while a product is still pending.
  always_comb begin
    hilo_out   = hi;
    hilo_stall = hilo_read & busy;
    if (hilo_sel) begin
      hilo_out = lo;
    end else begin
      hilo_out = hi;
    end
  end

  // Multiplier sequencer: IDLE -> CALC (WIDTH steps) -> SIGN -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      count_r  <= {CW{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {(2*WIDTH){1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      neg_r    <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start_mult) begin
            mcand_r  <= {{WIDTH{1'b0}}, magnitude(op_a, mult_sign)};
            mplier_r <= magnitude(op_b, mult_sign);
            neg_r    <= mult_sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_r    <= {(2*WIDTH){1'b0}};
            count_r  <= {CW{1'b0}};
            busy     <= 1'b1;
            state_r  <= CALC;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r    <= acc_next_s;
          mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
          count_r  <= count_r + ONE_C;
          if (count_r == LAST_COUNT) begin
            state_r <= SIGN;
          end else begin
            state_r <= CALC;
          end
        end
        SIGN: begin
          hi      <= result_s[2*WIDTH-1:WIDTH];
          lo      <= result_s[WIDTH-1:0];
          done    <= 1'b1;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule
